// File: rtl/resnet_tile_sched.sv
`default_nettype none
// ============================================================================
// resnet_tile_sched : per-tile ACT load, core kick, OP-row residual/ReLU pass
// Revision 1.0
// ============================================================================
module resnet_tile_sched #(
    parameter int NUM_TILES = 64,
    parameter int ACT_WORDS = 36,
    parameter int OP_ROWS   = 16,
    parameter int LANES     = 8,
    parameter int SRC_AW    = 12,
    parameter int RES_AW    = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        tile_idx,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [31:0]       src_q,
    output logic [RES_AW-1:0] res_addr,
    input  logic [31:0]       res_q,
    output logic              act_cen,
    output logic              act_wen,
    output logic [6:0]        act_addr,
    output logic [31:0]       act_d,
    output logic              seq_begin,
    input  logic              seq_done,
    output logic              cl_sel,
    output logic              op_cen,
    output logic              op_wen,
    output logic [3:0]        op_addr,
    output logic [127:0]      op_d,
    input  logic [127:0]      op_q
);

    localparam int WCW = $clog2(ACT_WORDS + 1);
    localparam int RCW = (OP_ROWS > 1) ? $clog2(OP_ROWS) : 1;
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [WCW-1:0] LAST_WORD  = WCW'(ACT_WORDS);
    localparam logic [RCW-1:0] LAST_ROW   = RCW'(OP_ROWS - 1);
    localparam logic [TCW-1:0] LAST_TICK  = TCW'(TIMEOUT - 1);
    localparam logic [5:0]     LAST_TILE  = 6'(NUM_TILES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        KICK = 3'd2,
        WAIT = 3'd3,
        PRD  = 3'd4,
        PWR  = 3'd5,
        NEXT = 3'd6,
        FIN  = 3'd7
    } state_t;

    state_t           state, state_next;
    logic [WCW-1:0]   word_cnt;
    logic [RCW-1:0]   row;
    logic [TCW-1:0]   timer;
    logic [SRC_AW-1:0] src_base;
    logic [RES_AW-1:0] res_base;
    logic [16*LANES-1:0] post_row;

    assign src_base = SRC_AW'(tile_idx) * SRC_AW'(ACT_WORDS);
    assign res_base = RES_AW'(tile_idx) * RES_AW'(OP_ROWS);

    // 17-bit sum cannot overflow: sign bit -> clamp to 0, bit 15 set -> clamp high.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [16:0] sum;
        assign sum = {op_q[16*n+15], op_q[16*n +: 16]} + {13'd0, res_q[4*n +: 4]};
        assign post_row[16*n +: 16] = sum[16] ? 16'h0000 :
                                      (sum[15] ? 16'h7FFF : sum[15:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tile_idx <= 6'd0;
            word_cnt <= '0;
            row      <= '0;
            timer    <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (run) begin
                    err      <= 1'b0;
                    tile_idx <= 6'd0;
                    word_cnt <= '0;
                    row      <= '0;
                    timer    <= '0;
                end
                LOAD: word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + WCW'(1);
                KICK: timer <= '0;
                WAIT: begin
                    timer <= timer + TCW'(1);
                    row   <= '0;
                    if (!seq_done && timer == LAST_TICK) err <= 1'b1;
                end
                PWR:  row <= (row == LAST_ROW) ? '0 : row + RCW'(1);
                NEXT: if (tile_idx != LAST_TILE) tile_idx <= tile_idx + 6'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        cl_sel     = 1'b1;
        seq_begin  = 1'b0;
        src_addr   = '0;
        res_addr   = '0;
        act_cen    = 1'b1;
        act_wen    = 1'b1;
        act_addr   = 7'd0;
        act_d      = 32'd0;
        op_cen     = 1'b1;
        op_wen     = 1'b1;
        op_addr    = 4'd0;
        op_d       = 128'd0;
        case (state)
            IDLE: if (run) state_next = LOAD;
            LOAD: begin
                if (word_cnt != LAST_WORD) src_addr = src_base + SRC_AW'(word_cnt);
                // Write lags the read address by one cycle to meet src_q latency.
                if (word_cnt != '0) begin
                    act_cen  = 1'b0;
                    act_wen  = 1'b0;
                    act_addr = 7'(word_cnt - WCW'(1));
                    act_d    = src_q;
                end
                if (word_cnt == LAST_WORD) state_next = KICK;
            end
            KICK: begin
                cl_sel     = 1'b0;
                seq_begin  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                cl_sel = 1'b0;
                if (seq_done)                state_next = PRD;
                else if (timer == LAST_TICK) state_next = FIN;
            end
            PRD: begin
                op_cen     = 1'b0;
                op_addr    = 4'(row);
                res_addr   = res_base + RES_AW'(row);
                state_next = PWR;
            end
            PWR: begin
                op_cen     = 1'b0;
                op_wen     = 1'b0;
                op_addr    = 4'(row);
                op_d       = 128'(post_row);
                res_addr   = res_base + RES_AW'(row);
                state_next = (row == LAST_ROW) ? NEXT : PRD;
            end
            NEXT: state_next = (tile_idx == LAST_TILE) ? FIN : LOAD;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

endmodule
`default_nettype wire
